// File: rtl/p_alu_iq_if.sv
// Dispatch and issue bundle for the ALU issue queue; the queue is the slave
// and the dispatch/ALU side is the master.
interface p_alu_iq_if #(
    parameter int PREG_W = 6,
    parameter int CTRL_W = 32
);
    logic                           in_valid_i;
    logic                           in_ready_o;
    logic [1:0]                     in_choose_i;
    logic [1:0][1:0][31:0]          in_src_data_i;
    logic [1:0][1:0][PREG_W-1:0]    in_src_preg_i;
    logic [1:0][1:0]                in_src_valid_i;
    logic [1:0][PREG_W-1:0]         in_dst_preg_i;
    logic [1:0][CTRL_W-1:0]         in_ctrl_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [1:0][31:0]               out_src_data_o;
    logic [PREG_W-1:0]              out_dst_preg_o;
    logic [CTRL_W-1:0]              out_ctrl_o;

    modport slave (
        input  in_valid_i, in_choose_i, in_src_data_i, in_src_preg_i,
               in_src_valid_i, in_dst_preg_i, in_ctrl_i, out_ready_i,
        output in_ready_o, out_valid_o, out_src_data_o, out_dst_preg_o, out_ctrl_o
    );

    modport master (
        output in_valid_i, in_choose_i, in_src_data_i, in_src_preg_i,
               in_src_valid_i, in_dst_preg_i, in_ctrl_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_src_data_o, out_dst_preg_o, out_ctrl_o
    );
endinterface

// File: rtl/p_alu_iq.sv
// Collapsing ALU issue queue: 2-wide enqueue, 2-port CDB wakeup, oldest-ready select.
// Optional perf counters enabled by defining IQ_PERF_CNT_EN.
module p_alu_iq_wake #(
    parameter int PREG_W = 6
) (
    input  logic                    v_i,
    input  logic [PREG_W-1:0]       p_i,
    input  logic [31:0]             d_i,
    input  logic [1:0]              cdb_valid_i,
    input  logic [1:0][PREG_W-1:0]  cdb_preg_i,
    input  logic [1:0][31:0]        cdb_data_i,
    output logic                    v_o,
    output logic [31:0]             d_o
);
    // Port 0 takes priority when both ports carry the same tag.
    always_comb begin
        v_o = v_i;
        d_o = d_i;
        if (!v_i) begin
            if (cdb_valid_i[0] && cdb_preg_i[0] == p_i) begin
                v_o = 1'b1;
                d_o = cdb_data_i[0];
            end else if (cdb_valid_i[1] && cdb_preg_i[1] == p_i) begin
                v_o = 1'b1;
                d_o = cdb_data_i[1];
            end
        end
    end
endmodule

module p_alu_iq #(
    parameter  int DEPTH  = 8,
    parameter  int PREG_W = 6,
    parameter  int CTRL_W = 32,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    p_alu_iq_if.slave               io,
    input  logic [1:0]              cdb_valid_i,
    input  logic [1:0][PREG_W-1:0]  cdb_preg_i,
    input  logic [1:0][31:0]        cdb_data_i,
    output logic [CW-1:0]           count_o,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             issue_cnt_o
);
    typedef struct packed {
        logic [1:0]               sv;
        logic [1:0][PREG_W-1:0]   sp;
        logic [1:0][31:0]         sd;
        logic [PREG_W-1:0]        dst;
        logic [CTRL_W-1:0]        ctrl;
    } ent_t;

    ent_t                   ent_q [DEPTH];
    ent_t                   ent_d [DEPTH];
    ent_t                   ent_n [DEPTH];
    ent_t                   in_n  [2];
    logic [CW-1:0]          count_q, count_d, base, pos1;
    logic [IW-1:0]          sel;
    logic                   sel_ok, iss, enq, in_rdy;
    logic [DEPTH-1:0][1:0]        wv;
    logic [DEPTH-1:0][1:0][31:0]  wd;
    logic [1:0][1:0]              iv;
    logic [1:0][1:0][31:0]        id;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        for (genvar s = 0; s < 2; s++) begin : g_src
            p_alu_iq_wake #(.PREG_W(PREG_W)) u_wk (
                .v_i(ent_q[i].sv[s]), .p_i(ent_q[i].sp[s]), .d_i(ent_q[i].sd[s]),
                .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i), .cdb_data_i(cdb_data_i),
                .v_o(wv[i][s]), .d_o(wd[i][s])
            );
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_in
        for (genvar s = 0; s < 2; s++) begin : g_src
            p_alu_iq_wake #(.PREG_W(PREG_W)) u_wk (
                .v_i(io.in_src_valid_i[k][s]), .p_i(io.in_src_preg_i[k][s]),
                .d_i(io.in_src_data_i[k][s]),
                .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i), .cdb_data_i(cdb_data_i),
                .v_o(iv[k][s]), .d_o(id[k][s])
            );
        end
    end

    // Descending scan so the lowest ready index wins.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && &ent_q[i].sv) begin
                sel    = IW'(i);
                sel_ok = 1'b1;
            end
        end
    end

    assign in_rdy            = (count_q <= CW'(DEPTH - 2));
    assign io.in_ready_o     = in_rdy;
    assign io.out_valid_o    = sel_ok;
    assign io.out_src_data_o = ent_q[sel].sd;
    assign io.out_dst_preg_o = ent_q[sel].dst;
    assign io.out_ctrl_o     = ent_q[sel].ctrl;
    assign count_o           = count_q;
    assign iss               = sel_ok & io.out_ready_i;
    assign enq               = io.in_valid_i & in_rdy;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            in_n[k].sv   = iv[k];
            in_n[k].sp   = io.in_src_preg_i[k];
            in_n[k].sd   = id[k];
            in_n[k].dst  = io.in_dst_preg_i[k];
            in_n[k].ctrl = io.in_ctrl_i[k];
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i]    = ent_q[i];
            ent_n[i].sv = wv[i];
            ent_n[i].sd = wd[i];
        end
        // Collapse over the issued slot, then append new entries at the new tail.
        for (int i = 0; i < DEPTH; i++)
            ent_d[i] = (iss && IW'(i) >= sel && i < DEPTH - 1) ? ent_n[(i + 1) % DEPTH] : ent_n[i];
        base = count_q - CW'(iss);
        pos1 = base + CW'(io.in_choose_i[0]);
        if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (io.in_choose_i[0] && CW'(i) == base) ent_d[i] = in_n[0];
                if (io.in_choose_i[1] && CW'(i) == pos1) ent_d[i] = in_n[1];
            end
        end
        count_d = enq ? pos1 + CW'(io.in_choose_i[1]) : base;
        if (flush_i) count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

`ifdef IQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, issue_cnt_q;

    // A flushed cycle's handshake does not count as an issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (io.in_valid_i && !in_rdy) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (iss && !flush_i)          issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign issue_cnt_o = issue_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign issue_cnt_o = '0;
`endif
endmodule
